// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, state type and defaults for the load/store unit
package lsu_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   localparam int TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DONE,
      ST_FAULT
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane steering: store strobes/replication, load extraction, legality
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] store_data,
   input  logic [2:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_ext,
   output logic        misaligned,
   output logic        illegal
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store side works on the live request; byte/half stores also accept the unsigned encodings.
   always_comb begin
      wstrb      = 4'b0000;
      wdata      = store_data;
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (st_size)
         SZ_B, SZ_BU: begin
            wstrb = 4'b0001 << st_off;
            wdata = {4{store_data[7:0]}};
         end
         SZ_H, SZ_HU: begin
            wstrb      = 4'b0011 << {st_off[1], 1'b0};
            wdata      = {2{store_data[15:0]}};
            misaligned = st_off[0];
         end
         SZ_W: begin
            wstrb      = 4'b1111;
            misaligned = (st_off != 2'b00);
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      ld_byte = rdata[7:0];
      case (ld_off)
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         2'd3:    ld_byte = rdata[31:24];
         default: ld_byte = rdata[7:0];
      endcase
      ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      load_ext = rdata;
      case (ld_size)
         SZ_B:    load_ext = {{24{ld_byte[7]}}, ld_byte};
         SZ_BU:   load_ext = {24'h0, ld_byte};
         SZ_H:    load_ext = {{16{ld_half[15]}}, ld_half};
         SZ_HU:   load_ext = {16'h0, ld_half};
         default: load_ext = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding data memory access sequencer with abort on timeout
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  byte_select,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        done,
   output logic [31:0] load_data,
   output logic        fault,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_t  state, state_next;
   logic [7:0]  cnt;
   logic [2:0]  lat_size;
   logic [1:0]  lat_off;
   logic        accept;
   logic        stall_c;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [31:0] al_load;
   logic        al_misaligned;
   logic        al_illegal;

   lsu_align u_align (
      .st_size    (byte_select),
      .st_off     (addr[1:0]),
      .store_data (store_data),
      .ld_size    (lat_size),
      .ld_off     (lat_off),
      .rdata      (dmem_rdata),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .load_ext   (al_load),
      .misaligned (al_misaligned),
      .illegal    (al_illegal)
   );

   always_comb begin
      state_next = state;
      stall_c    = 1'b0;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_read || mem_write) begin
               stall_c = 1'b1;
               if ((mem_read && mem_write) || al_illegal || al_misaligned) begin
                  state_next = ST_FAULT;
               end else begin
                  accept     = 1'b1;
                  state_next = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            stall_c = 1'b1;
            if (dmem_ack)
               state_next = ST_DONE;
            else if (cnt >= TO_LAST)
               state_next = ST_FAULT;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Reset must silence stall even while the core still presents the old access.
   assign stall = stall_c & ~rst;
   assign done  = (state == ST_DONE);
   assign fault = (state == ST_FAULT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= 8'h00;
         lat_size   <= 3'b000;
         lat_off    <= 2'b00;
         load_data  <= 32'h0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'h0;
         dmem_wdata <= 32'h0;
         dmem_wstrb <= 4'b0000;
      end else begin
         state    <= state_next;
         dmem_req <= (state_next == ST_REQ);
         if (accept) begin
            lat_size   <= byte_select;
            lat_off    <= addr[1:0];
            dmem_we    <= mem_write;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_wdata <= al_wdata;
            dmem_wstrb <= mem_write ? al_wstrb : 4'b0000;
         end
         if (accept)
            cnt <= 8'h00;
         else if (state == ST_REQ && cnt != 8'hFF)
            cnt <= cnt + 8'h01;
         if (state == ST_REQ && dmem_ack && !dmem_we)
            load_data <= al_load;
      end
   end

endmodule
